// File: rtl/p09_spi_pkg.sv
// Shared types and command encodings for the p09 SPI receiver.
package p09_spi_pkg;

  typedef enum logic [7:0] {
    SPI_NOP   = 8'h00,
    SPI_WRITE = 8'h01,
    SPI_READ  = 8'h02
  } spi_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WADDR,
    ST_WDATA,
    ST_RADDR,
    ST_RDATA,
    ST_IGNORE
  } spi_state_e;

  localparam logic [7:0] CMD_NOP_BYTE   = SPI_NOP;
  localparam logic [7:0] CMD_WRITE_BYTE = SPI_WRITE;
  localparam logic [7:0] CMD_READ_BYTE  = SPI_READ;

endpackage

// File: rtl/p09_sync2.sv
// Two-flop synchronizer for one asynchronous pin, reset value selectable per pin.
module p09_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/p09_spi_receiver.sv
// SPI mode-0 slave: synchronizes the pins, assembles bytes and turns the
// NOP/WRITE/READ command protocol into register write/read strobes.
//
// state     | meaning
// IDLE      | CS high or not yet seen a fresh CS fall
// CMD       | collecting the command byte (NOPs loop here)
// WADDR     | collecting the write start address
// WDATA     | each byte is written, address auto-increments
// RADDR     | collecting the read start address
// RDATA     | each byte read out on MISO, next address requested
// IGNORE    | unknown command, waiting for CS high
module p09_spi_receiver
  import p09_spi_pkg::*;
#(
  parameter int SCLK_RATIO_MIN = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  input  logic       spi_cs,
  output logic       spi_miso,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       rd_req,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       cmd_error
);

  logic sclk_s, mosi_s, cs_s;

  p09_sync2 #(.RST_VAL(1'b0)) u_sync_sclk (.clk(clk), .reset_n(reset_n), .d_i(spi_sclk), .q_o(sclk_s));
  p09_sync2 #(.RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .reset_n(reset_n), .d_i(spi_mosi), .q_o(mosi_s));
  p09_sync2 #(.RST_VAL(1'b1)) u_sync_cs   (.clk(clk), .reset_n(reset_n), .d_i(spi_cs),   .q_o(cs_s));

  logic       sclk_dly_q, cs_dly_q;
  logic       sclk_rise_q, sclk_fall_q, cs_rise_q, cs_fall_q;
  logic [1:0] settle_q;
  logic       armed_q;
  logic [3:0] gap_q;

  // A CS pin already low when reset releases must not look like a frame start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_dly_q  <= 1'b0;
      cs_dly_q    <= 1'b1;
      sclk_rise_q <= 1'b0;
      sclk_fall_q <= 1'b0;
      cs_rise_q   <= 1'b0;
      cs_fall_q   <= 1'b0;
      settle_q    <= 2'd0;
      armed_q     <= 1'b0;
      gap_q       <= 4'hF;
    end else begin
      sclk_dly_q  <= sclk_s;
      cs_dly_q    <= cs_s;
      sclk_rise_q <= sclk_s & ~sclk_dly_q;
      sclk_fall_q <= ~sclk_s & sclk_dly_q;
      cs_rise_q   <= cs_s & ~cs_dly_q;
      cs_fall_q   <= ~cs_s & cs_dly_q & armed_q;
      if (settle_q != 2'd3) settle_q <= settle_q + 2'd1;
      if (settle_q == 2'd3 && cs_s) armed_q <= 1'b1;
      if (sclk_rise_q) gap_q <= 4'd0;
      else if (gap_q != 4'hF) gap_q <= gap_q + 4'd1;
    end
  end

  assert property (@(posedge clk) disable iff (!reset_n)
    sclk_rise_q |-> 32'(gap_q) >= SCLK_RATIO_MIN - 1);

  spi_state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] rx_sr_q, rx_sr_d;
  logic [7:0] waddr_q, waddr_d;
  logic [7:0] wr_addr_q, wr_addr_d, wr_data_q, wr_data_d, rd_addr_q, rd_addr_d;
  logic [7:0] miso_sr_q, miso_sr_d;
  logic       wr_valid_q, wr_valid_d, rd_req_q, rd_req_d, cmd_error_q, cmd_error_d;
  logic       rd_load_q, rd_load_d;
  logic       active, byte_done;
  logic [7:0] rx_byte;

  assign active    = (state_q != ST_IDLE);
  assign rx_byte   = {rx_sr_q, mosi_s};
  assign byte_done = active & sclk_rise_q & (bit_cnt_q == 3'd7) & ~cs_rise_q;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_sr_d     = rx_sr_q;
    waddr_d     = waddr_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    rd_addr_d   = rd_addr_q;
    miso_sr_d   = miso_sr_q;
    wr_valid_d  = 1'b0;
    rd_req_d    = 1'b0;
    cmd_error_d = 1'b0;
    rd_load_d   = rd_req_q;

    if (sclk_rise_q && active) begin
      bit_cnt_d = bit_cnt_q + 3'd1;
      rx_sr_d   = rx_byte[6:0];
    end

    case (state_q)
      ST_IDLE:  if (cs_fall_q) state_d = ST_CMD;
      ST_CMD: begin
        if (byte_done) begin
          case (rx_byte)
            CMD_NOP_BYTE:   state_d = ST_CMD;
            CMD_WRITE_BYTE: state_d = ST_WADDR;
            CMD_READ_BYTE:  state_d = ST_RADDR;
            default: begin
              cmd_error_d = 1'b1;
              state_d     = ST_IGNORE;
            end
          endcase
        end
      end
      ST_WADDR: begin
        if (byte_done) begin
          waddr_d = rx_byte;
          state_d = ST_WDATA;
        end
      end
      ST_WDATA: begin
        if (byte_done) begin
          wr_valid_d = 1'b1;
          wr_addr_d  = waddr_q;
          wr_data_d  = rx_byte;
          waddr_d    = waddr_q + 8'd1;
        end
      end
      ST_RADDR: begin
        if (byte_done) begin
          rd_addr_d = rx_byte;
          rd_req_d  = 1'b1;
          state_d   = ST_RDATA;
        end
      end
      ST_RDATA: begin
        if (byte_done) begin
          rd_addr_d = rd_addr_q + 8'd1;
          rd_req_d  = 1'b1;
        end
      end
      ST_IGNORE: state_d = ST_IGNORE;
      default:   state_d = ST_IDLE;
    endcase

    // The fall right after a byte boundary presents the freshly loaded MSB, so it must not shift.
    if (rd_load_q) miso_sr_d = rd_data;
    else if (sclk_fall_q && active && bit_cnt_q != 3'd0) miso_sr_d = {miso_sr_q[6:0], 1'b0};

    if (cs_fall_q) bit_cnt_d = 3'd0;
    if (cs_rise_q) begin
      state_d   = ST_IDLE;
      bit_cnt_d = 3'd0;
      miso_sr_d = 8'h00;
      rd_load_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      rx_sr_q     <= 7'd0;
      waddr_q     <= 8'h00;
      wr_addr_q   <= 8'h00;
      wr_data_q   <= 8'h00;
      rd_addr_q   <= 8'h00;
      miso_sr_q   <= 8'h00;
      wr_valid_q  <= 1'b0;
      rd_req_q    <= 1'b0;
      cmd_error_q <= 1'b0;
      rd_load_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_sr_q     <= rx_sr_d;
      waddr_q     <= waddr_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rd_addr_q   <= rd_addr_d;
      miso_sr_q   <= miso_sr_d;
      wr_valid_q  <= wr_valid_d;
      rd_req_q    <= rd_req_d;
      cmd_error_q <= cmd_error_d;
      rd_load_q   <= rd_load_d;
    end
  end

  assign spi_miso  = ~cs_s & miso_sr_q[7];
  assign wr_valid  = wr_valid_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign rd_req    = rd_req_q;
  assign rd_addr   = rd_addr_q;
  assign cmd_error = cmd_error_q;

endmodule
